// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back, write-allocate data cache with true-LRU
module set_assoc_cache #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 8,
    parameter int NUM_WAYS  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   is_input_valid,
    input  logic                   mem_rw,
    input  logic [31:0]            addr,
    input  logic [31:0]            din,
    output logic                   is_ready,
    output logic                   is_output_valid,
    output logic                   is_hit,
    output logic [31:0]            dout,
    output logic                   mem_is_input_valid,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_addr,
    output logic [LINE_SIZE*8-1:0] mem_din,
    input  logic                   mem_is_output_valid,
    input  logic [LINE_SIZE*8-1:0] mem_dout,
    input  logic                   mem_ready,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int OFF    = $clog2(LINE_SIZE);
    localparam int IDX    = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF - IDX;
    localparam int IDX_W  = (IDX > 0) ? IDX : 1;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WS_W   = (OFF > 2) ? OFF - 2 : 1;
    localparam int LINE_W = LINE_SIZE * 8;

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP} state_t;
    state_t state, next_state;

    logic              valid_q [NUM_WAYS][NUM_SETS];
    logic              dirty_q [NUM_WAYS][NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0] line_q  [NUM_WAYS][NUM_SETS];
    logic [WAY_W-1:0]  age_q   [NUM_WAYS][NUM_SETS];

    logic [31:0]      lat_addr, lat_din;
    logic             lat_rw;
    logic [WAY_W-1:0] lat_way;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return IDX_W'((a >> OFF) & (NUM_SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return TAG_W'(a >> (OFF + IDX));
    endfunction

    function automatic logic [WS_W-1:0] ws_of(input logic [31:0] a);
        return WS_W'((a & (LINE_SIZE - 1)) >> 2);
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
        return (32'(t) << (OFF + IDX)) | (32'(i) << OFF);
    endfunction

    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] l, input logic [WS_W-1:0] ws);
        return l[32*int'(ws) +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] set_word(input logic [LINE_W-1:0] l, input logic [WS_W-1:0] ws,
                                                   input logic [31:0] d);
        logic [LINE_W-1:0] r;
        r = l;
        r[32*int'(ws) +: 32] = d;
        return r;
    endfunction

    logic [IDX_W-1:0] req_idx, lat_idx, touch_set;
    logic [TAG_W-1:0] req_tag, lat_tag;
    logic [WS_W-1:0]  req_ws, lat_ws;
    logic             hit, found, accept, touch_en;
    logic [WAY_W-1:0] hit_way, victim, max_age, touch_way;

    assign req_idx = idx_of(addr);
    assign req_tag = tag_of(addr);
    assign req_ws  = ws_of(addr);
    assign lat_idx = idx_of(lat_addr);
    assign lat_tag = tag_of(lat_addr);
    assign lat_ws  = ws_of(lat_addr);
    assign accept  = (state == IDLE) && is_input_valid;

    // Tag match, then victim: lowest invalid way, else the oldest way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        found   = 1'b0;
        max_age = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[w][req_idx] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[w][req_idx] >= max_age) begin
                    max_age = age_q[w][req_idx];
                    victim  = WAY_W'(w);
                end
            end
        end
    end

    assign touch_en  = (accept && hit) || (state == RESP);
    assign touch_set = (state == RESP) ? lat_idx : req_idx;
    assign touch_way = (state == RESP) ? lat_way : hit_way;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state         = state;
        is_ready           = 1'b0;
        is_output_valid    = 1'b0;
        is_hit             = 1'b0;
        dout               = '0;
        mem_is_input_valid = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_addr           = '0;
        mem_din            = '0;
        case (state)
            IDLE: begin
                is_ready = 1'b1;
                if (is_input_valid) begin
                    if (hit) begin
                        is_output_valid = 1'b1;
                        is_hit          = 1'b1;
                        dout            = get_word(line_q[hit_way][req_idx], req_ws);
                    end else begin
                        next_state = (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? WB_REQ : FILL_REQ;
                    end
                end
            end
            WB_REQ: begin
                mem_is_input_valid = 1'b1;
                mem_write          = 1'b1;
                mem_addr           = line_addr(tag_q[lat_way][lat_idx], lat_idx);
                mem_din            = line_q[lat_way][lat_idx];
                if (mem_ready) next_state = WB_WAIT;
            end
            WB_WAIT: begin
                if (mem_ready) next_state = FILL_REQ;
            end
            FILL_REQ: begin
                mem_is_input_valid = 1'b1;
                mem_read           = 1'b1;
                mem_addr           = line_addr(lat_tag, lat_idx);
                if (mem_ready) next_state = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_is_output_valid) next_state = RESP;
            end
            RESP: begin
                is_output_valid = 1'b1;
                dout            = get_word(line_q[lat_way][lat_idx], lat_ws);
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                    line_q[w][s]  <= '0;
                    age_q[w][s]   <= WAY_W'(w);
                end
            end
            lat_addr   <= '0;
            lat_din    <= '0;
            lat_rw     <= 1'b0;
            lat_way    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept) begin
                if (hit) begin
                    hit_count <= hit_count + 32'd1;
                    if (mem_rw) begin
                        line_q[hit_way][req_idx]  <= set_word(line_q[hit_way][req_idx], req_ws, din);
                        dirty_q[hit_way][req_idx] <= 1'b1;
                    end
                end else begin
                    lat_addr <= addr;
                    lat_din  <= din;
                    lat_rw   <= mem_rw;
                    lat_way  <= victim;
                end
            end
            if (state == FILL_WAIT && mem_is_output_valid) begin
                valid_q[lat_way][lat_idx] <= 1'b1;
                dirty_q[lat_way][lat_idx] <= lat_rw;
                tag_q[lat_way][lat_idx]   <= lat_tag;
                line_q[lat_way][lat_idx]  <= lat_rw ? set_word(mem_dout, lat_ws, lat_din) : mem_dout;
            end
            if (state == RESP) miss_count <= miss_count + 32'd1;
            // Touched way becomes youngest; only ways younger than it age by one.
            if (touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_q[w][touch_set] <= '0;
                    else if (age_q[w][touch_set] < age_q[touch_way][touch_set])
                        age_q[w][touch_set] <= age_q[w][touch_set] + WAY_W'(1);
                end
            end
        end
    end
endmodule
